// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the write-back stage.
//   wb_sel_e  : write-back source select (ALU result, PC+4, load data, CSR data)
//   F3_*      : load funct3 encodings understood by the load formatter
//   funct3_t  : funct3 field type
// -----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_PC4  = 2'd1,
        WB_LOAD = 2'd2,
        WB_CSR  = 2'd3
    } wb_sel_e;

    typedef logic [2:0] funct3_t;

    localparam funct3_t F3_LB  = 3'b000;
    localparam funct3_t F3_LH  = 3'b001;
    localparam funct3_t F3_LW  = 3'b010;
    localparam funct3_t F3_LBU = 3'b100;
    localparam funct3_t F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// -----------------------------------------------------------------------------
// wb_load_align
// Purely combinational load formatter. Moves the addressed byte lane down to
// bit 0 and sign- or zero-extends according to the load type.
//   word   in  XLEN            raw data-memory word
//   offset in  log2(XLEN/8)    byte offset inside the word
//   funct3 in  3               load type
//   data   out XLEN            formatted load value
// Misaligned halfword/word loads simply see zeros shifted in from the top;
// unsupported funct3 values pass the raw word through untouched.
// -----------------------------------------------------------------------------
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]           word,
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  funct3_t                   funct3,
    output logic [XLEN-1:0]           data
);

    logic [XLEN-1:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        // NOTE: default assignment first so every path drives data; no latch.
        data = word;
        case (funct3)
            F3_LB:   data = XLEN'($signed(shifted[7:0]));
            F3_LH:   data = XLEN'($signed(shifted[15:0]));
            F3_LW:   data = XLEN'($signed(shifted[31:0]));
            F3_LBU:  data = XLEN'(shifted[7:0]);
            F3_LHU:  data = XLEN'(shifted[15:0]);
            default: data = word;
        endcase
    end

endmodule

// File: rtl/wb_arb_stage.sv
// -----------------------------------------------------------------------------
// wb_arb_stage
// Registered RV32/RV64 write-back stage. Selects and formats the MEM-stage
// result and arbitrates the register-file write port between the in-order
// pipeline (P) and a long-latency unit (L) with bounded starvation of L.
//   clk, rst_n        clock, async active-low reset
//   mem_*             MEM-stage instruction and its result sources
//   flush             kill the current MEM-stage instruction
//   lu_valid/rd/data  long-latency result
//   lu_ready   out    L accepted this cycle (combinational)
//   mem_stall  out    MEM must hold its inputs this cycle (combinational)
//   rf_we/waddr/wdata registered register-file write port
//   rf_from_lu out    registered: current write comes from L
// -----------------------------------------------------------------------------
module wb_arb_stage
    import wb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int MAX_WAIT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_valid,
    input  logic               mem_we,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [1:0]         mem_wb_sel,
    input  logic [XLEN-1:0]    mem_opr_res,
    input  logic [XLEN-1:0]    mem_pc,
    input  logic [XLEN-1:0]    mem_rdata,
    input  logic [XLEN-1:0]    mem_csr_rdata,
    input  logic [2:0]         mem_funct3,
    input  logic               flush,
    input  logic               lu_valid,
    input  logic [RADDR_W-1:0] lu_rd,
    input  logic [XLEN-1:0]    lu_data,
    output logic               lu_ready,
    output logic               mem_stall,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               rf_from_lu
);

    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int WC_W  = $clog2(MAX_WAIT + 1);

    wb_sel_e         sel;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] p_wdata;
    logic            p_cand;
    logic            l_cand;
    logic            l_prio;
    logic            grant_p;
    logic            grant_l;
    logic            l_write;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_nxt;

    assign sel = wb_sel_e'(mem_wb_sel);

    wb_load_align #(.XLEN(XLEN)) u_load_align (
        .word   (mem_rdata),
        .offset (mem_opr_res[OFF_W-1:0]),
        .funct3 (funct3_t'(mem_funct3)),
        .data   (load_data)
    );

    always_comb begin
        p_wdata = mem_opr_res;
        case (sel)
            WB_ALU:  p_wdata = mem_opr_res;
            WB_PC4:  p_wdata = mem_pc + XLEN'(4);
            WB_LOAD: p_wdata = load_data;
            WB_CSR:  p_wdata = mem_csr_rdata;
            default: p_wdata = mem_opr_res;
        endcase
    end

    // Instructions that do not write (rd=0, we=0, flushed) are not candidates,
    // so they never cost L a cycle; flush reaches mem_stall only through here.
    assign p_cand  = mem_valid & mem_we & (mem_rd != '0) & ~flush;
    assign l_cand  = lu_valid;
    assign l_prio  = (wait_cnt == WC_W'(MAX_WAIT));
    assign grant_l = l_cand & (~p_cand | l_prio);
    assign grant_p = p_cand & ~grant_l;

    // An L result targeting x0 is consumed but never written.
    assign l_write = grant_l & (lu_rd != '0);

    assign lu_ready  = grant_l;
    assign mem_stall = p_cand & grant_l;

    // Count denials of a waiting L; any grant or gap in lu_valid restarts it.
    always_comb begin
        wait_nxt = '0;
        if (l_cand && !grant_l && !l_prio) begin
            wait_nxt = wait_cnt + WC_W'(1);
        end else if (l_cand && !grant_l) begin
            wait_nxt = wait_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rf_from_lu <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments for all registered state so every
            // flop samples pre-edge values regardless of statement order.
            rf_we      <= grant_p | l_write;
            rf_from_lu <= l_write;
            wait_cnt   <= wait_nxt;
            if (l_write) begin
                rf_waddr <= lu_rd;
                rf_wdata <= lu_data;
            end else if (grant_p) begin
                rf_waddr <= mem_rd;
                rf_wdata <= p_wdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_arb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_arb_stage
// Self-checking bench for wb_arb_stage (XLEN=32, RADDR_W=5, MAX_WAIT=2).
// Directed steps followed by a randomized phase, all compared against a
// behavioural model of the arbitration and formatting rules.
// -----------------------------------------------------------------------------
module tb_wb_arb_stage;

    localparam int XLEN     = 32;
    localparam int RADDR_W  = 5;
    localparam int MAX_WAIT = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               mem_valid;
    logic               mem_we;
    logic [RADDR_W-1:0] mem_rd;
    logic [1:0]         mem_wb_sel;
    logic [XLEN-1:0]    mem_opr_res;
    logic [XLEN-1:0]    mem_pc;
    logic [XLEN-1:0]    mem_rdata;
    logic [XLEN-1:0]    mem_csr_rdata;
    logic [2:0]         mem_funct3;
    logic               flush;
    logic               lu_valid;
    logic [RADDR_W-1:0] lu_rd;
    logic [XLEN-1:0]    lu_data;
    logic               lu_ready;
    logic               mem_stall;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0]    rf_wdata;
    logic               rf_from_lu;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int                 m_denied;
    logic               m_we;
    logic               m_from_lu;
    logic [RADDR_W-1:0] m_addr;
    logic [XLEN-1:0]    m_data;

    always #5 clk = ~clk;

    wb_arb_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_valid     (mem_valid),
        .mem_we        (mem_we),
        .mem_rd        (mem_rd),
        .mem_wb_sel    (mem_wb_sel),
        .mem_opr_res   (mem_opr_res),
        .mem_pc        (mem_pc),
        .mem_rdata     (mem_rdata),
        .mem_csr_rdata (mem_csr_rdata),
        .mem_funct3    (mem_funct3),
        .flush         (flush),
        .lu_valid      (lu_valid),
        .lu_rd         (lu_rd),
        .lu_data       (lu_data),
        .lu_ready      (lu_ready),
        .mem_stall     (mem_stall),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .rf_from_lu    (rf_from_lu)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Load value from byte arithmetic: pick the lane, then extend by value range.
    function automatic logic [31:0] load_ref(input logic [31:0] w, input int off, input logic [2:0] f3);
        longint unsigned v;
        v = longint'(w) >> (8 * off);
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v + 64'hFFFF_FF00; end
            3'd1: begin v = v % 65536; if (v >= 32768) v = v + 64'hFFFF_0000; end
            3'd2: v = v % 64'h1_0000_0000;
            3'd4: v = v % 256;
            3'd5: v = v % 65536;
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    task automatic model_reset();
        m_denied  = 0;
        m_we      = 1'b0;
        m_from_lu = 1'b0;
        m_addr    = '0;
        m_data    = '0;
    endtask

    task automatic set_idle();
        mem_valid = 0; mem_we = 0; mem_rd = '0; mem_wb_sel = 2'd0;
        mem_opr_res = '0; mem_pc = '0; mem_rdata = '0; mem_csr_rdata = '0;
        mem_funct3 = 3'd0; flush = 0; lu_valid = 0; lu_rd = '0; lu_data = '0;
    endtask

    task automatic rand_inputs();
        mem_valid     = ($urandom_range(0, 3) != 0);
        mem_we        = ($urandom_range(0, 3) != 0);
        mem_rd        = ($urandom_range(0, 7) == 0) ? '0 : RADDR_W'($urandom);
        mem_wb_sel    = 2'($urandom);
        mem_opr_res   = $urandom;
        mem_pc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
        mem_rdata     = $urandom;
        mem_csr_rdata = $urandom;
        mem_funct3    = 3'($urandom);
        flush         = ($urandom_range(0, 7) == 0);
        lu_valid      = ($urandom_range(0, 1) != 0);
        lu_rd         = ($urandom_range(0, 7) == 0) ? '0 : RADDR_W'($urandom);
        lu_data       = $urandom;
    endtask

    task automatic set_conflict(input logic [RADDR_W-1:0] prd, input logic [RADDR_W-1:0] lrd);
        mem_valid = 1; mem_we = 1; mem_rd = prd; mem_wb_sel = 2'd0;
        mem_opr_res = $urandom; flush = 0;
        lu_valid = 1; lu_rd = lrd; lu_data = $urandom;
    endtask

    // One cycle: called just after a rising edge with inputs already driven.
    task automatic do_cycle(input string tag);
        bit p, l, take_l;
        logic [31:0] val;
        p      = mem_valid && mem_we && (mem_rd != 0) && !flush;
        l      = lu_valid;
        take_l = l && (!p || m_denied >= MAX_WAIT);
        case (mem_wb_sel)
            2'd0:    val = mem_opr_res;
            2'd1:    val = mem_pc + 32'd4;
            2'd2:    val = load_ref(mem_rdata, int'(mem_opr_res[1:0]), mem_funct3);
            default: val = mem_csr_rdata;
        endcase
        #2;
        check({tag, ".lu_ready"},  64'(lu_ready),  64'(take_l));
        check({tag, ".mem_stall"}, 64'(mem_stall), 64'(p && take_l));
        m_denied = (l && !take_l) ? m_denied + 1 : 0;
        if (take_l && lu_rd != 0) begin
            m_we = 1; m_from_lu = 1; m_addr = lu_rd; m_data = lu_data;
        end else if (p && !take_l) begin
            m_we = 1; m_from_lu = 0; m_addr = mem_rd; m_data = val;
        end else begin
            m_we = 0; m_from_lu = 0;
        end
        @(posedge clk);
        #1;
        check({tag, ".rf_we"},    64'(rf_we),    64'(m_we));
        check({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(m_addr));
        check({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(m_data));
        if (m_we) check({tag, ".rf_from_lu"}, 64'(rf_from_lu), 64'(m_from_lu));
    endtask

    logic [1:0]  ld_off [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
    logic [2:0]  ld_f3  [4] = '{3'b000, 3'b000, 3'b101, 3'b001};
    logic [31:0] ld_exp [4] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF, 32'h0000_7F01};

    initial begin
        // Reset held with random inputs
        rst_n = 0;
        set_idle();
        model_reset();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            @(posedge clk);
            #1;
            check("rst.rf_we",      64'(rf_we),      64'd0);
            check("rst.rf_waddr",   64'(rf_waddr),   64'd0);
            check("rst.rf_wdata",   64'(rf_wdata),   64'd0);
            check("rst.rf_from_lu", 64'(rf_from_lu), 64'd0);
        end
        set_idle();
        rst_n = 1;

        // First write after reset
        mem_valid = 1; mem_we = 1; mem_rd = 5'd5; mem_wb_sel = 2'd0; mem_opr_res = 32'h1234;
        do_cycle("alu");
        check("alu.wdata_const", 64'(rf_wdata), 64'h1234);
        check("alu.waddr_const", 64'(rf_waddr), 64'd5);

        // Load formatting
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1; mem_we = 1; mem_rd = 5'd7; mem_wb_sel = 2'd2;
            mem_rdata = 32'h80FF_7F01; mem_opr_res = {30'd0, ld_off[i]}; mem_funct3 = ld_f3[i];
            do_cycle("load");
            check("load.const", 64'(rf_wdata), 64'(ld_exp[i]));
        end

        // PC+4 wrap
        mem_wb_sel = 2'd1; mem_pc = 32'hFFFF_FFFC; mem_rd = 5'd1;
        do_cycle("pc4");
        check("pc4.wrap", 64'(rf_wdata), 64'd0);

        // Idle cycle: no write, outputs hold
        set_idle();
        do_cycle("idle");

        // Continuous conflict: L serviced every third cycle
        for (int i = 0; i < 6; i++) begin
            set_conflict(5'd3, 5'd9);
            #1;
            check("starve.ready_pat", 64'(lu_ready),  64'(i % 3 == 2));
            check("starve.stall_pat", 64'(mem_stall), 64'(i % 3 == 2));
            do_cycle("starve");
            check("starve.from_lu", 64'(rf_from_lu), 64'(i % 3 == 2));
        end

        set_idle();
        do_cycle("idle2");

        // rd=0 instruction alongside L: no conflict
        set_conflict(5'd0, 5'd12);
        #1;
        check("rd0.ready", 64'(lu_ready),  64'd1);
        check("rd0.stall", 64'(mem_stall), 64'd0);
        do_cycle("rd0");
        check("rd0.from_lu", 64'(rf_from_lu), 64'd1);

        // Flush during conflict after one denial clears the wait count
        set_conflict(5'd4, 5'd13);
        do_cycle("pre_flush");
        set_conflict(5'd4, 5'd14);
        flush = 1;
        #1;
        check("flush.ready", 64'(lu_ready),  64'd1);
        check("flush.stall", 64'(mem_stall), 64'd0);
        do_cycle("flush");
        check("flush.waddr", 64'(rf_waddr), 64'd14);
        set_conflict(5'd4, 5'd15);
        #1;
        check("post_flush.ready", 64'(lu_ready), 64'd0);
        do_cycle("post_flush");

        // L to x0 alone: accepted, no write
        set_idle();
        lu_valid = 1; lu_rd = '0; lu_data = $urandom;
        do_cycle("lu_x0");

        // Reset asserted mid-conflict
        set_idle();
        do_cycle("idle3");
        set_conflict(5'd6, 5'd17);
        do_cycle("pre_rst");
        rst_n = 0;
        #1;
        check("midrst.rf_we",    64'(rf_we),    64'd0);
        check("midrst.rf_waddr", 64'(rf_waddr), 64'd0);
        check("midrst.rf_wdata", 64'(rf_wdata), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            set_conflict(5'd6, 5'd17);
            #1;
            check("midrst.ready_pat", 64'(lu_ready), 64'(i == 2));
            do_cycle("post_rst");
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            do_cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
